axil_cmd_master: RTL and testbench
==================================

AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, byte-address width of the AXI4-Lite bus.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 SHALL have parameter TIMEOUT, default 255, the wait-cycle limit before the timeout flag is set; 0 disables the watchdog.
REQ-004 SHALL have the following ports, clock and reset first:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  captured BRESP/RRESP.
- m_axi_awaddr/awprot/awvalid/awready  out/out/out/in  ADDR_WIDTH/3/1/1  AW channel.
- m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1  W channel.
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  B channel.
- m_axi_araddr/arprot/arvalid/arready  out/out/out/in  ADDR_WIDTH/3/1/1  AR channel.
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  DATA_WIDTH/2/1/1  R channel.
- err_cnt  out  8  saturating count of non-OKAY responses.
- timeout_flag  out  1  sticky watchdog flag.
- timeout_clr  in  1  clears timeout_flag.

Function
REQ-005 SHALL implement the FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA and RSP; exactly one transaction is outstanding at any time.
REQ-006 SHALL drive cmd_ready=1 only in IDLE; on a cmd_valid&&cmd_ready handshake it SHALL register addr, wdata, wstrb and write, then go to WR_REQ (write) or RD_REQ (read).
REQ-007 WR_REQ: awvalid and wvalid SHALL both be high in the first cycle after command acceptance.
- Each SHALL drop the cycle after its own handshake, independently of the other.
- AW and W may complete in either order or in the same cycle.
- When both have completed, the FSM SHALL go to WR_RESP.
REQ-008 WR_RESP: bready SHALL be 1; on bvalid&&bready the block SHALL capture bresp, set rsp_rdata=0 and rsp_write=1, then go to RSP.
REQ-009 RD_REQ: arvalid SHALL be 1 until arready; on that handshake the FSM SHALL go to RD_DATA.
REQ-010 RD_DATA: rready SHALL be 1; on rvalid&&rready the block SHALL capture rdata and rresp, set rsp_write=0, then go to RSP.
REQ-011 RSP: rsp_valid SHALL be 1 with stable data until rsp_ready, then the FSM SHALL return to IDLE.
- A new command cannot be accepted in the cycle of the rsp handshake.
- Minimum command-to-command spacing is therefore RSP exit + 1 cycle.
REQ-012 Address, data and strobe outputs SHALL hold stable while their VALID is high; awprot and arprot SHALL be 3'b000.
- Addresses pass through unmodified; unaligned addresses are not realigned.
REQ-013 AXI VALID outputs SHALL never depend combinationally on the corresponding READY inputs.
REQ-014 err_cnt SHALL increment when entering RSP with resp!=2'b00 and saturate at 8'hFF.
REQ-015 Watchdog:
- A wait counter SHALL count cycles spent in WR_REQ, WR_RESP, RD_REQ and RD_DATA, and reset to 0 on each state change.
- When the counter equals TIMEOUT (TIMEOUT!=0), timeout_flag SHALL set.
- The transaction SHALL NOT be abandoned; the FSM keeps waiting.
REQ-016 timeout_clr SHALL clear timeout_flag; if set and clear occur in the same cycle, set SHALL win.

Reset
REQ-017 While ARESETn=0, the block SHALL force the following, asynchronously:
- State to IDLE.
- All AXI VALID/READY outputs, cmd_ready and rsp_valid to 0.
- rsp_rdata, rsp_resp, rsp_write, err_cnt, timeout_flag and the wait counter to 0.
REQ-018 cmd_ready SHALL rise in the first clock after ARESETn deasserts.
REQ-019 Reset mid-transaction SHALL discard the transaction with no response generated.

Verification
REQ-020 Write: cmd write addr 0x04 data 0x00000010 wstrb 0xF; slave with 0-cycle ready -> awvalid and wvalid high 1 cycle, bready high, rsp_valid with resp=00 and rdata=0.
REQ-021 Read: cmd read 0x04 from a slave returning 0x00000010 -> arvalid, then rready, then rsp_rdata=0x00000010, rsp_write=0.
REQ-022 Skewed write: wready 3 cycles before awready, and the reverse -> each VALID drops independently, exactly one B accepted, one response produced.
REQ-023 Error, backpressure and saturation:
- Slave returns rresp=2'b10 and rsp_ready is held low 5 cycles -> rsp_valid and data stable, err_cnt=1.
- 300 error responses -> err_cnt=0xFF.
REQ-024 Timeout with TIMEOUT=4 and awready held low:
- timeout_flag=1 after 4 wait cycles; transaction completes when awready rises.
- timeout_clr then gives timeout_flag=0.
REQ-025 ARESETn pulsed during RD_DATA -> all VALID/READY outputs 0 immediately, no rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/axil_cmd_master.sv
// AXI4-Lite master that turns a cmd/rsp handshake pair into exactly one outstanding
// AXI transaction, with a saturating error counter and a sticky stall watchdog.
module axil_cmd_master #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic [7:0]              err_cnt,
  output logic                    timeout_flag,
  input  logic                    timeout_clr
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]           wstrb_q, wstrb_d;
  logic                    rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_resp_q, rsp_resp_d;
  logic [7:0]              err_cnt_q, err_cnt_d;
  logic                    timeout_flag_q, timeout_flag_d;
  logic [CW-1:0]           wait_cnt_q, wait_cnt_d;

  logic                    aw_done, w_done, capture, wait_state;
  logic [1:0]              resp_in;

  always_comb begin
    state_d        = state_q;
    awvalid_d      = awvalid_q;
    wvalid_d       = wvalid_q;
    arvalid_d      = arvalid_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    rsp_write_d    = rsp_write_q;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_resp_d     = rsp_resp_q;
    err_cnt_d      = err_cnt_q;
    timeout_flag_d = timeout_flag_q;
    wait_cnt_d     = wait_cnt_q;
    capture        = 1'b0;
    resp_in        = 2'b00;
    aw_done        = !awvalid_q || m_axi_awready;
    w_done         = !wvalid_q || m_axi_wready;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        // AW and W retire independently; move on once both have.
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done)          state_d   = WR_RESP;
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          capture     = 1'b1;
          resp_in     = m_axi_bresp;
          rsp_resp_d  = m_axi_bresp;
          rsp_rdata_d = '0;
          rsp_write_d = 1'b1;
          state_d     = RSP;
        end
      end
      RD_REQ: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_axi_rvalid) begin
          capture     = 1'b1;
          resp_in     = m_axi_rresp;
          rsp_resp_d  = m_axi_rresp;
          rsp_rdata_d = m_axi_rdata;
          rsp_write_d = 1'b0;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (capture && (resp_in != 2'b00) && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;

    // Counter restarts on every state change and parks at TIMEOUT while stuck.
    wait_state = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                 (state_q == RD_REQ) || (state_q == RD_DATA);
    if (!wait_state || (state_d != state_q))
      wait_cnt_d = '0;
    else if (wait_cnt_q != TO_CNT)
      wait_cnt_d = wait_cnt_q + CW'(1);

    if (timeout_clr) timeout_flag_d = 1'b0;
    if ((TIMEOUT != 0) && wait_state && (wait_cnt_d == TO_CNT))
      timeout_flag_d = 1'b1;

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q        <= IDLE;
      cmd_ready_q    <= 1'b0;
      awvalid_q      <= 1'b0;
      wvalid_q       <= 1'b0;
      arvalid_q      <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      rsp_write_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_resp_q     <= 2'b00;
      err_cnt_q      <= 8'h00;
      timeout_flag_q <= 1'b0;
      wait_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      cmd_ready_q    <= cmd_ready_d;
      awvalid_q      <= awvalid_d;
      wvalid_q       <= wvalid_d;
      arvalid_q      <= arvalid_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      rsp_write_q    <= rsp_write_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_resp_q     <= rsp_resp_d;
      err_cnt_q      <= err_cnt_d;
      timeout_flag_q <= timeout_flag_d;
      wait_cnt_q     <= wait_cnt_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = (state_q == RSP);
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (state_q == WR_RESP);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = (state_q == RD_DATA);
  assign err_cnt       = err_cnt_q;
  assign timeout_flag  = timeout_flag_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: directed and randomized transactions against a
// cycle-schedule model derived from slave delays, checked every cycle.
module tb_axil_cmd_master;

  localparam int TO = 4;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [5:0]  m_axi_awaddr, m_axi_araddr;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic [7:0]  err_cnt;
  logic        timeout_flag, timeout_clr;

  axil_cmd_master #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .err_cnt(err_cnt), .timeout_flag(timeout_flag), .timeout_clr(timeout_clr)
  );

  always #5 ACLK = ~ACLK;

  int n_pass = 0;
  int n_total = 0;

  // Expected outputs for the current cycle, set by the stimulus side.
  logic        chk_en = 1'b0;
  logic        exp_cmd_ready, exp_awvalid, exp_wvalid, exp_bready;
  logic        exp_arvalid, exp_rready, exp_rsp_valid, exp_rsp_write, exp_flag;
  logic [31:0] exp_rsp_rdata, exp_wdata;
  logic [1:0]  exp_rsp_resp;
  logic [7:0]  exp_err;
  logic [5:0]  exp_addr;
  logic [3:0]  exp_wstrb;
  int          err_m = 0;
  logic        flag_m = 1'b0;
  int          cur_k = 0;

  // Observations used by the hand-computed literal checks.
  int          n_b = 0, n_rsp = 0, rise_k = -1;
  logic        flag_prev = 1'b0;
  logic [31:0] got_rdata;
  logic [1:0]  got_resp;
  logic        got_write;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
  endfunction

  function automatic void exp_idle();
    exp_cmd_ready = 1'b1; exp_awvalid = 1'b0; exp_wvalid = 1'b0; exp_bready = 1'b0;
    exp_arvalid = 1'b0; exp_rready = 1'b0; exp_rsp_valid = 1'b0;
  endfunction

  function automatic void slave_idle();
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = 32'h0; m_axi_rresp = 2'b00;
  endfunction

  initial forever begin
    @(negedge ACLK);
    if (m_axi_bvalid && m_axi_bready) n_b++;
    if (rsp_valid && rsp_ready) begin
      n_rsp++; got_rdata = rsp_rdata; got_resp = rsp_resp; got_write = rsp_write;
    end
    if (timeout_flag && !flag_prev) rise_k = cur_k;
    flag_prev = timeout_flag;
    if (chk_en) begin
      chk("cmd_ready", cmd_ready, exp_cmd_ready);
      chk("awvalid", m_axi_awvalid, exp_awvalid);
      chk("wvalid", m_axi_wvalid, exp_wvalid);
      chk("bready", m_axi_bready, exp_bready);
      chk("arvalid", m_axi_arvalid, exp_arvalid);
      chk("rready", m_axi_rready, exp_rready);
      chk("rsp_valid", rsp_valid, exp_rsp_valid);
      chk("err_cnt", err_cnt, exp_err);
      chk("timeout_flag", timeout_flag, exp_flag);
      chk("awprot", m_axi_awprot, 3'b000);
      chk("arprot", m_axi_arprot, 3'b000);
      if (exp_awvalid) chk("awaddr", m_axi_awaddr, exp_addr);
      if (exp_wvalid) begin
        chk("wdata", m_axi_wdata, exp_wdata);
        chk("wstrb", m_axi_wstrb, exp_wstrb);
      end
      if (exp_arvalid) chk("araddr", m_axi_araddr, exp_addr);
      if (exp_rsp_valid) begin
        chk("rsp_write", rsp_write, exp_rsp_write);
        chk("rsp_rdata", rsp_rdata, exp_rsp_rdata);
        chk("rsp_resp", rsp_resp, exp_rsp_resp);
      end
    end
  end

  // Start a new cycle and advance the sticky-flag model (clear uses last cycle's input).
  task automatic cyc_begin(input bit set_now);
    @(posedge ACLK); #1;
    if (set_now) flag_m = 1'b1;
    else if (timeout_clr) flag_m = 1'b0;
    exp_flag = flag_m;
    exp_err  = 8'(err_m);
  endtask

  task automatic idle(input int n, input bit clr);
    for (int i = 0; i < n; i++) begin
      cyc_begin(1'b0);
      cmd_valid = 1'b0; timeout_clr = clr; rsp_ready = 1'($urandom);
      exp_idle();
    end
  endtask

  // One transaction, entered in a cycle where the DUT is idle. Slave delays:
  // write d1=AW wait, d2=W wait, d3=B wait; read d1=AR wait, d3=R wait; rd=rsp wait.
  task automatic run_txn(input bit wr, input logic [5:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int d1, input int d2, input int d3,
                         input int rd, input logic [31:0] rdata, input logic [1:0] resp,
                         input int clr_k, input int rst_k);
    int e1, s2, e2, s, e;
    e1 = wr ? 1 + ((d1 > d2) ? d1 : d2) : 1 + d1;
    s2 = e1 + 1;
    e2 = s2 + d3;
    s  = e2 + 1;
    e  = s + rd;
    cur_k = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = wstrb;
    exp_addr = addr; exp_wdata = wdata; exp_wstrb = wstrb;
    exp_rsp_write = wr; exp_rsp_rdata = wr ? 32'h0 : rdata; exp_rsp_resp = resp;
    for (int k = 1; k <= e; k++) begin
      cyc_begin(((k >= 1 + TO) && (k <= e1)) || ((k >= s2 + TO) && (k <= e2)));
      cur_k = k;
      if (k == s && resp != 2'b00 && err_m < 255) err_m++;
      exp_err = 8'(err_m);
      cmd_valid = 1'($urandom); cmd_write = 1'($urandom);
      cmd_addr = 6'($urandom); cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
      timeout_clr   = (k == clr_k);
      m_axi_awready = wr && (k == 1 + d1);
      m_axi_wready  = wr && (k == 1 + d2);
      m_axi_bvalid  = wr && (k == e2);
      m_axi_bresp   = resp;
      m_axi_arready = !wr && (k == e1);
      m_axi_rvalid  = !wr && (k == e2);
      m_axi_rdata   = (k == e2) ? rdata : $urandom;
      m_axi_rresp   = resp;
      rsp_ready     = (k == e) || ((k < s) && 1'($urandom));
      exp_cmd_ready = 1'b0;
      exp_awvalid   = wr && (k <= 1 + d1);
      exp_wvalid    = wr && (k <= 1 + d2);
      exp_bready    = wr && (k >= s2) && (k <= e2);
      exp_arvalid   = !wr && (k <= e1);
      exp_rready    = !wr && (k >= s2) && (k <= e2);
      exp_rsp_valid = (k >= s);
      if (k == rst_k) begin
        chk_en = 1'b0;
        #2 ARESETn = 1'b0;
        #1;
        chk("rst_awvalid", m_axi_awvalid, 1'b0);
        chk("rst_wvalid", m_axi_wvalid, 1'b0);
        chk("rst_bready", m_axi_bready, 1'b0);
        chk("rst_arvalid", m_axi_arvalid, 1'b0);
        chk("rst_rready", m_axi_rready, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_err_cnt", err_cnt, 8'h00);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        slave_idle(); cmd_valid = 1'b0; rsp_ready = 1'b0; timeout_clr = 1'b0;
        @(posedge ACLK); #1;
        chk("rst_hold_rsp_valid", rsp_valid, 1'b0);
        ARESETn = 1'b1;
        #1 chk("rel_cmd_ready_low", cmd_ready, 1'b0);
        err_m = 0; flag_m = 1'b0;
        cyc_begin(1'b0);
        chk("rel_cmd_ready_high", cmd_ready, 1'b1);
        chk("rel_rsp_valid", rsp_valid, 1'b0);
        exp_idle();
        chk_en = 1'b1;
        return;
      end
    end
    cyc_begin(1'b0);
    cur_k = e + 1;
    cmd_valid = 1'b0; timeout_clr = 1'b0; rsp_ready = 1'b0;
    slave_idle();
    exp_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected end of run by t=1000000");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    int nb0, nr0;
    ARESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0; timeout_clr = 1'b0;
    slave_idle();
    repeat (2) @(posedge ACLK);
    #1;
    chk("reset_cmd_ready", cmd_ready, 1'b0);
    chk("reset_awvalid", m_axi_awvalid, 1'b0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_err_cnt", err_cnt, 8'h00);
    chk("reset_timeout_flag", timeout_flag, 1'b0);
    ARESETn = 1'b1;
    cyc_begin(1'b0);
    chk("first_clk_cmd_ready", cmd_ready, 1'b1);
    exp_idle();
    chk_en = 1'b1;

    // Plain write, zero-wait slave.
    nb0 = n_b;
    run_txn(1'b1, 6'h04, 32'h0000_0010, 4'hF, 0, 0, 0, 0, 32'h0, 2'b00, -1, -1);
    chk("req020_rdata", got_rdata, 32'h0);
    chk("req020_resp", got_resp, 2'b00);
    chk("req020_write", got_write, 1'b1);
    chk("req020_b_count", n_b - nb0, 1);

    // Plain read.
    run_txn(1'b0, 6'h04, 32'h0, 4'h0, 0, 0, 0, 0, 32'h0000_0010, 2'b00, -1, -1);
    chk("req021_rdata", got_rdata, 32'h0000_0010);
    chk("req021_write", got_write, 1'b0);

    // Skewed writes: W three cycles ahead of AW, then the reverse.
    nb0 = n_b; nr0 = n_rsp;
    run_txn(1'b1, 6'h09, 32'hA5A5_0001, 4'h3, 3, 0, 1, 0, 32'h0, 2'b00, -1, -1);
    chk("req022a_b_count", n_b - nb0, 1);
    chk("req022a_rsp_count", n_rsp - nr0, 1);
    nb0 = n_b; nr0 = n_rsp;
    run_txn(1'b1, 6'h13, 32'h5A5A_0002, 4'hC, 0, 3, 0, 1, 32'h0, 2'b00, -1, -1);
    chk("req022b_b_count", n_b - nb0, 1);
    chk("req022b_rsp_count", n_rsp - nr0, 1);

    // SLVERR read with response backpressure.
    run_txn(1'b0, 6'h20, 32'h0, 4'h0, 1, 0, 2, 5, 32'hDEAD_BEEF, 2'b10, -1, -1);
    chk("req023_err_cnt", err_cnt, 8'h01);
    chk("req023_rdata", got_rdata, 32'hDEAD_BEEF);
    chk("req023_resp", got_resp, 2'b10);

    // AW stalled for 6 cycles: flag appears in the 5th WR_REQ cycle and survives completion.
    run_txn(1'b1, 6'h3C, 32'h1234_5678, 4'hF, 6, 0, 0, 0, 32'h0, 2'b00, -1, -1);
    chk("req024_rise_cycle", rise_k, 5);
    chk("req024_sticky", timeout_flag, 1'b1);
    idle(1, 1'b1);
    idle(1, 1'b0);
    chk("req024_cleared", timeout_flag, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      idle($urandom_range(0, 2), 1'b0);
      run_txn(1'($urandom), 6'($urandom), $urandom, 4'($urandom),
              $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
              $urandom_range(0, 4), $urandom, 2'($urandom_range(0, 3)),
              $urandom_range(0, 20), -1);
    end

    // Reset pulse while waiting in RD_DATA.
    nr0 = n_rsp;
    run_txn(1'b0, 6'h08, 32'h0, 4'h0, 0, 0, 3, 0, 32'hCAFE_F00D, 2'b00, -1, 3);
    chk("req025_no_rsp", n_rsp - nr0, 0);
    chk("req025_err_cleared", err_cnt, 8'h00);

    // Error burst to saturate the counter.
    for (int i = 0; i < 300; i++)
      run_txn(1'($urandom), 6'($urandom), $urandom, 4'($urandom), 0, 0, 0, 0,
              $urandom, 2'($urandom_range(1, 3)), -1, -1);
    chk("req023_saturate", err_cnt, 8'hFF);

    idle(2, 1'b0);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
